iotdf_param: RTL and testbench

Parametrised IoT data filter: the next generation of the team's fixed 128-bit, 8-bit-serial filtering engine. It accepts samples of `DATA_W` bits serially, `IN_W` bits per beat, MSB-first. It applies one of five functions selected by `fn_sel`: group max, group min, group average, range extract, or range exclude. Results are reported on a `DATA_W`-bit output with a one-cycle `valid` pulse. It sits between the sensor byte stream and the downstream result collector.

---
 rtl/iotdf_param_if.sv | 27 ++
 rtl/iotdf_param.sv | 165 ++++++++++++++++
 tb/tb_iotdf_param.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/iotdf_param_if.sv
// Bus bundle for the parametrised IoT data filter: sample beats, function select,
// range bounds in one direction and busy/valid/result in the other.
interface iotdf_param_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned IN_W   = 8
);
    logic              in_en;
    logic [IN_W-1:0]   iot_in;
    logic [2:0]        fn_sel;
    logic [DATA_W-1:0] low;
    logic [DATA_W-1:0] high;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] iot_out;

    // Source side: the sensor stream plus the configuration it carries
    modport master (
        output in_en, iot_in, fn_sel, low, high,
        input  busy, valid, iot_out
    );

    // Filter side
    modport slave (
        input  in_en, iot_in, fn_sel, low, high,
        output busy, valid, iot_out
    );
endinterface

// File: rtl/iotdf_param.sv
// Parametrised IoT data filter. Assembles DATA_W-bit samples from IN_W-bit MSB-first
// beats, then in a single CALC cycle applies group max/min/avg or range extract/exclude.
// Build option: define IOTDF_AVG_EN to build the group-average function and its
// widened accumulator; without it fn_sel=3 behaves as an invalid function.
// DATA_W must be a multiple of IN_W; GROUP is a power of two, at least 2.
module iotdf_param #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned GROUP  = 8
) (
    input logic         clk,
    input logic         rst_n,
    iotdf_param_if.slave bus
);
    localparam int unsigned BEATS = DATA_W / IN_W;
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned GW    = (GROUP > 1) ? $clog2(GROUP) : 1;

    localparam logic [2:0] FnMax = 3'd1;
    localparam logic [2:0] FnMin = 3'd2;
`ifdef IOTDF_AVG_EN
    localparam logic [2:0] FnAvg = 3'd3;
`endif
    localparam logic [2:0] FnExt = 3'd4;
    localparam logic [2:0] FnExc = 3'd5;

    typedef enum logic {StLoad, StCalc} state_t;

    state_t            state;
    logic [BCW-1:0]    beat_cnt;
    logic [GW-1:0]     sample_cnt;
    logic [2:0]        fn;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] extreme;
    logic [DATA_W-1:0] out_val;
    logic              valid_r;

    logic              accept;
    logic              first_of_group;
    logic              last_of_group;
    logic [DATA_W-1:0] ext_next;
    logic              in_range;
    logic              out_range;

    assign accept         = bus.in_en && (state == StLoad);
    assign first_of_group = (sample_cnt == '0);
    assign last_of_group  = (sample_cnt == GW'(GROUP - 1));

    assign bus.busy    = (state == StCalc);
    assign bus.valid   = valid_r;
    assign bus.iot_out = out_val;

    // Candidate extreme: first sample of a group always loads; ties keep the stored value
    always_comb begin
        ext_next = extreme;
        if (first_of_group ||
            (fn == FnMax && sample > extreme) ||
            (fn == FnMin && sample < extreme)) begin
            ext_next = sample;
        end
    end

    // Strict range tests against bounds sampled in the CALC cycle
    always_comb begin
        in_range  = (sample > bus.low) && (sample < bus.high);
        out_range = (sample < bus.low) || (sample > bus.high);
    end

`ifdef IOTDF_AVG_EN
    logic [DATA_W+GW-1:0] acc;
    logic [DATA_W+GW-1:0] acc_next;
    logic [DATA_W+GW-1:0] acc_shift;

    // Accumulator is GW bits wider than a sample, so a full group cannot overflow
    always_comb begin
        if (first_of_group) begin
            acc_next = {{GW{1'b0}}, sample};
        end else begin
            acc_next = acc + {{GW{1'b0}}, sample};
        end
        acc_shift = acc_next >> GW;
    end
`endif

    // Two-state LOAD/CALC FSM with registered busy/valid/result and all datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StLoad;
            beat_cnt   <= '0;
            sample_cnt <= '0;
            fn         <= '0;
            sample     <= '0;
            extreme    <= '0;
            out_val    <= '0;
            valid_r    <= 1'b0;
`ifdef IOTDF_AVG_EN
            acc        <= '0;
`endif
        end else begin
            valid_r <= 1'b0;
            unique case (state)
                StLoad: begin
                    if (accept) begin
                        sample <= (sample << IN_W) | DATA_W'(bus.iot_in);
                        // Function is only re-latched at a group boundary; range and
                        // invalid functions never advance sample_cnt, so they re-latch
                        // on every sample.
                        if (beat_cnt == '0 && first_of_group) begin
                            fn <= bus.fn_sel;
                        end
                        if (beat_cnt == BCW'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= StCalc;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                StCalc: begin
                    state <= StLoad;
                    case (fn)
                        FnMax, FnMin: begin
                            extreme <= ext_next;
                            if (last_of_group) begin
                                out_val    <= ext_next;
                                valid_r    <= 1'b1;
                                sample_cnt <= '0;
                            end else begin
                                sample_cnt <= sample_cnt + GW'(1);
                            end
                        end
`ifdef IOTDF_AVG_EN
                        FnAvg: begin
                            acc <= acc_next;
                            if (last_of_group) begin
                                out_val    <= acc_shift[DATA_W-1:0];
                                valid_r    <= 1'b1;
                                sample_cnt <= '0;
                            end else begin
                                sample_cnt <= sample_cnt + GW'(1);
                            end
                        end
`endif
                        FnExt: begin
                            if (in_range) begin
                                out_val <= sample;
                                valid_r <= 1'b1;
                            end
                        end
                        FnExc: begin
                            if (out_range) begin
                                out_val <= sample;
                                valid_r <= 1'b1;
                            end
                        end
                        default: begin
                            // Invalid function: sample consumed, nothing updated
                        end
                    endcase
                end
                default: state <= StLoad;
            endcase
        end
    end
endmodule

// File: tb/tb_iotdf_param.sv
// Self-checking bench for iotdf_param (DATA_W=128, IN_W=8, GROUP=8). Expected results
// are pushed to a scoreboard when the last beat of a sample is driven and popped when
// valid is observed; unexpected valids and wrong output cycles are flagged.
module tb_iotdf_param;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned GROUP  = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   seq;
    bit   prev_valid;
    exp_t sb[$];
    int   busy_at[$];

    iotdf_param_if #(.DATA_W(DATA_W), .IN_W(IN_W)) bus_if ();

    iotdf_param #(
        .DATA_W(DATA_W),
        .IN_W  (IN_W),
        .GROUP (GROUP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every valid must match the oldest expectation in value and cycle
    always @(negedge clk) begin
        if (bus_if.valid === 1'b1) begin
            check_eq("valid_gap", DATA_W'(prev_valid), '0);
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", DATA_W'(sb.size()), DATA_W'(1));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("iot_out", bus_if.iot_out, e.data);
                check_eq("valid_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
            end
        end
        prev_valid = (bus_if.valid === 1'b1);
    end

    // Drive nb beats of x MSB-first; beats seen with busy high are re-presented.
    // Returns at the negedge where the final beat is presented, with its cycle in last_cyc.
    task automatic send(input logic [DATA_W-1:0] x, input logic [2:0] fn, input int nb,
                        output int last_cyc);
        int i;
        int tries;
        i = 0;
        tries = 0;
        last_cyc = 0;
        while (i < nb) begin
            @(negedge clk);
            seq++;
            tries++;
            bus_if.in_en  = 1'b1;
            bus_if.iot_in = x[DATA_W-1-IN_W*i -: IN_W];
            bus_if.fn_sel = fn;
            if (bus_if.busy === 1'b0) begin
                last_cyc = cyc;
                i++;
            end else begin
                busy_at.push_back(seq);
            end
            if (tries > 4 * nb + 8) begin
                check_eq("beat_accept_timeout", DATA_W'(i), DATA_W'(nb));
                i = nb;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.in_en = 1'b0;
        end
    endtask

    task automatic expect_out(input logic [DATA_W-1:0] v, input int last_cyc);
        exp_t e;
        e.data = v;
        e.cyc  = last_cyc + 2;
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] r[3];
        int t;
        checks = 0;
        errors = 0;
        seq = 0;
        cyc = 0;
        prev_valid = 1'b0;
        ones = '1;
        rst_n = 1'b0;
        bus_if.in_en  = 1'b0;
        bus_if.iot_in = '0;
        bus_if.fn_sel = 3'd0;
        bus_if.low    = '0;
        bus_if.high   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", DATA_W'(bus_if.busy), '0);
        check_eq("rst_valid", DATA_W'(bus_if.valid), '0);
        check_eq("rst_iot_out", bus_if.iot_out, '0);
        rst_n = 1'b1;
        idle(2);

        // Range extract / exclude with bounds just below 0x7.. and at 0xA..F
        bus_if.low  = {4'h6, {124{1'b1}}};
        bus_if.high = {4'hA, {124{1'b1}}};
        v = {4'h7, 124'h0};
        send(v, 3'd4, 16, t); expect_out(v, t); idle(2);
        send(bus_if.high, 3'd4, 16, t); idle(2);
        send(bus_if.low, 3'd4, 16, t); idle(2);
        send(bus_if.high, 3'd5, 16, t); idle(2);
        send(bus_if.low, 3'd5, 16, t); idle(2);
        v = {4'hB, 124'h0};
        send(v, 3'd5, 16, t); expect_out(v, t); idle(2);
        v = 128'h5;
        send(v, 3'd5, 16, t); expect_out(v, t); idle(2);

        // Invalid functions consume the sample silently
        send(128'h1234, 3'd0, 16, t); idle(1);
        send(128'h5678, 3'd7, 16, t); idle(3);

        // Reset after beat 5 discards the partial sample and iot_out
        bus_if.low  = '0;
        bus_if.high = ones;
        send(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 3'd4, 6, t);
        @(negedge clk);
        bus_if.in_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", DATA_W'(bus_if.busy), '0);
        check_eq("midrst_valid", DATA_W'(bus_if.valid), '0);
        check_eq("midrst_iot_out", bus_if.iot_out, '0);
        v = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
        send(v, 3'd4, 16, t); expect_out(v, t); idle(2);

        // Group max: 1..8 with sample 5 all-ones
        for (int k = 1; k <= 8; k++) begin
            v = (k == 5) ? ones : DATA_W'(k);
            send(v, 3'd1, 16, t);
            if (k == 8) expect_out(ones, t);
            idle(1);
        end
        idle(2);

        // Group min with duplicate minima; fn_sel flips to max after sample 3
        for (int k = 0; k < 8; k++) begin
            logic [DATA_W-1:0] mv[8];
            mv = '{128'h90, 128'h33, 128'h70, 128'h55, 128'h33, 128'h80, 128'h60, 128'h40};
            send(mv[k], (k < 3) ? 3'd2 : 3'd1, 16, t);
            if (k == 7) expect_out(128'h33, t);
            idle(1);
        end
        idle(2);

        // Group average: 1..8 -> 4, then eight all-ones -> all-ones
        for (int k = 1; k <= 8; k++) begin
            send(DATA_W'(k), 3'd3, 16, t);
`ifdef IOTDF_AVG_EN
            if (k == 8) expect_out(128'h4, t);
`endif
            idle(1);
        end
        for (int k = 1; k <= 8; k++) begin
            send(ones, 3'd3, 16, t);
`ifdef IOTDF_AVG_EN
            if (k == 8) expect_out(ones, t);
`endif
            idle(1);
        end
        idle(2);

        // Back-to-back samples with in_en held high: busy on cycles 17, 34, 51
        for (int k = 0; k < 3; k++) begin
            r[k] = {$urandom, $urandom, $urandom, $urandom};
            r[k] = (r[k] & {1'b0, {127{1'b1}}}) | 128'h1;
        end
        busy_at.delete();
        seq = 0;
        for (int k = 0; k < 3; k++) begin
            send(r[k], 3'd4, 16, t);
            expect_out(r[k], t);
        end
        @(negedge clk);
        check_eq("busy_c51", DATA_W'(bus_if.busy), DATA_W'(1));
        bus_if.in_en = 1'b0;
        check_eq("busy_count", DATA_W'(busy_at.size()), DATA_W'(2));
        if (busy_at.size() == 2) begin
            check_eq("busy_c17", DATA_W'(busy_at[0]), DATA_W'(17));
            check_eq("busy_c34", DATA_W'(busy_at[1]), DATA_W'(34));
        end
        idle(6);

        check_eq("sb_left", DATA_W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
